// File: rtl/wb_reg_bank.sv
// Wishbone (pipelined) register bank with per-bit RW / RO / W1C bit types,
// base-prefix decode and a configurable number of wait states before ack.
module wb_reg_bank #(
  parameter int unsigned REG_COUNT      = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned WB_ADDR_WIDTH  = 20,
  parameter int unsigned BASE_WIDTH     = 4,
  parameter logic [BASE_WIDTH-1:0] BASE = 4'b0100,
  parameter int unsigned REG_ADDR_WIDTH = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] RESET_VALUES = '0,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] WRITE_MASK   = '1,
  parameter logic [REG_COUNT*DATA_WIDTH-1:0] W1C_MASK     = '0,
  parameter int unsigned WAIT_STATES    = 0
) (
  input  logic                            wb_clock_i,
  input  logic                            wb_reset_n_i,
  input  logic [WB_ADDR_WIDTH-1:0]        wb_addr_i,
  input  logic [DATA_WIDTH-1:0]           wb_data_i,
  output logic [DATA_WIDTH-1:0]           wb_data_o,
  input  logic                            wb_we_i,
  input  logic                            wb_cycle_i,
  input  logic                            wb_strobe_i,
  output logic                            wb_stall_o,
  output logic                            wb_ack_o,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] ro_i,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] status_set_i,
  output logic [REG_COUNT*DATA_WIDTH-1:0] regs_o,
  output logic [REG_COUNT-1:0]            write_strobe_o
);

  localparam int unsigned TOTAL_W = REG_COUNT * DATA_WIDTH;
  localparam int unsigned CNT_W   = 4;

  // W1C wins over RW; everything that is neither is a live read-only bit.
  localparam logic [TOTAL_W-1:0] W1C_M   = W1C_MASK;
  localparam logic [TOTAL_W-1:0] RW_M    = WRITE_MASK & ~W1C_MASK;
  localparam logic [TOTAL_W-1:0] STORE_M = RW_M | W1C_M;
  localparam logic [TOTAL_W-1:0] RO_M    = ~STORE_M;

  localparam logic [CNT_W-1:0] WS_LAST = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [REG_ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      we_q;
  logic                      ack_q;
  logic                      stall_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [REG_COUNT-1:0]      wstb_q;
  logic [TOTAL_W-1:0]        regs_q;
  logic [TOTAL_W-1:0]        regs_d;

  logic                      sel_c;
  logic                      enter_ack_c;
  logic [REG_ADDR_WIDTH-1:0] xfer_idx_c;
  logic [DATA_WIDTH-1:0]     xfer_data_c;
  logic                      xfer_we_c;
  logic [REG_COUNT-1:0]      wr_hit_c;
  logic [TOTAL_W-1:0]        wr_en_c;
  logic [TOTAL_W-1:0]        wdata_rep_c;
  logic [TOTAL_W-1:0]        read_img_c;
  logic [DATA_WIDTH-1:0]     rd_c;
  logic                      unused_addr_c;

  // Address bits between the prefix and the index are intentionally ignored.
  assign unused_addr_c = ^wb_addr_i;

  // Decode, transfer selection, next register image and read mux.
  always_comb begin
    sel_c = wb_cycle_i & wb_strobe_i & (state_q == S_IDLE) &
            (wb_addr_i[WB_ADDR_WIDTH-1 -: BASE_WIDTH] == BASE);

    // With zero wait states the commit edge is the accept edge, so use the bus directly.
    if (state_q == S_IDLE) begin
      xfer_idx_c  = wb_addr_i[REG_ADDR_WIDTH-1:0];
      xfer_data_c = wb_data_i;
      xfer_we_c   = wb_we_i;
    end else begin
      xfer_idx_c  = idx_q;
      xfer_data_c = wdata_q;
      xfer_we_c   = we_q;
    end

    enter_ack_c = (sel_c && (WAIT_STATES == 0)) ||
                  ((state_q == S_WAIT) && wb_cycle_i && (cnt_q == WS_LAST));

    wr_hit_c    = '0;
    wr_en_c     = '0;
    rd_c        = '0;
    wdata_rep_c = {REG_COUNT{xfer_data_c}};
    read_img_c  = (regs_q & STORE_M) | (ro_i & RO_M);
    for (int r = 0; r < REG_COUNT; r++) begin
      if (xfer_idx_c == REG_ADDR_WIDTH'(r)) begin
        wr_hit_c[r] = enter_ack_c & xfer_we_c;
        rd_c        = read_img_c[r*DATA_WIDTH +: DATA_WIDTH];
      end
      wr_en_c[r*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{wr_hit_c[r]}};
    end

    // RW bits take write data; W1C bits clear on 1; hardware set applied last so it wins.
    regs_d = (regs_q & ~(wr_en_c & RW_M)) | (wdata_rep_c & wr_en_c & RW_M);
    regs_d = regs_d & ~(wr_en_c & W1C_M & wdata_rep_c);
    regs_d = regs_d | (status_set_i & W1C_M);
    regs_d = regs_d & STORE_M;
  end

  // Register storage; RO bit positions are held at zero.
  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      regs_q <= RESET_VALUES & STORE_M;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bus FSM with registered ack, stall, read data and write strobes.
  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      rdata_q <= '0;
      wstb_q  <= '0;
    end else begin
      ack_q  <= 1'b0;
      wstb_q <= '0;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (sel_c) begin
            idx_q   <= wb_addr_i[REG_ADDR_WIDTH-1:0];
            wdata_q <= wb_data_i;
            we_q    <= wb_we_i;
            stall_q <= 1'b1;
            cnt_q   <= '0;
            if (WAIT_STATES == 0) begin
              state_q <= S_ACK;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!wb_cycle_i) begin
            state_q <= S_IDLE;
            stall_q <= 1'b0;
          end else if (cnt_q == WS_LAST) begin
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
        end
      endcase
      if (enter_ack_c) begin
        ack_q   <= 1'b1;
        wstb_q  <= wr_hit_c;
        rdata_q <= xfer_we_c ? '0 : rd_c;
      end
    end
  end

  assign wb_ack_o       = ack_q;
  assign wb_stall_o     = stall_q;
  assign wb_data_o      = rdata_q;
  assign write_strobe_o = wstb_q;
  assign regs_o         = regs_q;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed bench for wb_reg_bank: three instances (0 / 3 / 1 wait states).
module tb_wb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [19:0] addr = '0;
  logic [7:0]  wd = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cyc = '0;
  logic [31:0] ro = 32'hC300_0000;
  logic [31:0] sset = '0;

  logic [2:0]  ack, stall;
  logic [7:0]  rd0, rd1, rd2;
  logic [31:0] regs0, regs1;
  logic [23:0] regs2;
  logic [3:0]  wstb0, wstb1;
  logic [2:0]  wstb2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: 4 regs, no wait states; reg2 W1C, reg3 RO
  wb_reg_bank #(.REG_COUNT(4), .RESET_VALUES(32'h0000_A503), .WRITE_MASK(32'h0000_FFFF),
                .W1C_MASK(32'h00FF_0000), .WAIT_STATES(0)) u0 (
    .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wd), .wb_data_o(rd0),
    .wb_we_i(we), .wb_cycle_i(cyc[0]), .wb_strobe_i(stb), .wb_stall_o(stall[0]), .wb_ack_o(ack[0]),
    .ro_i(ro), .status_set_i(sset), .regs_o(regs0), .write_strobe_o(wstb0));

  // u1: same map, three wait states
  wb_reg_bank #(.REG_COUNT(4), .RESET_VALUES(32'h0000_A503), .WRITE_MASK(32'h0000_FFFF),
                .W1C_MASK(32'h00FF_0000), .WAIT_STATES(3)) u1 (
    .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wd), .wb_data_o(rd1),
    .wb_we_i(we), .wb_cycle_i(cyc[1]), .wb_strobe_i(stb), .wb_stall_o(stall[1]), .wb_ack_o(ack[1]),
    .ro_i(ro), .status_set_i(sset), .regs_o(regs1), .write_strobe_o(wstb1));

  // u2: 3 regs all RW, one wait state
  wb_reg_bank #(.REG_COUNT(3), .RESET_VALUES(24'h00A503), .WRITE_MASK('1),
                .W1C_MASK('0), .WAIT_STATES(1)) u2 (
    .wb_clock_i(clk), .wb_reset_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wd), .wb_data_o(rd2),
    .wb_we_i(we), .wb_cycle_i(cyc[2]), .wb_strobe_i(stb), .wb_stall_o(stall[2]), .wb_ack_o(ack[2]),
    .ro_i(ro[23:0]), .status_set_i(sset[23:0]), .regs_o(regs2), .write_strobe_o(wstb2));

  typedef struct {
    int         d;
    logic       w;
    logic [3:0] pfx;
    logic [1:0] idx;
    logic [7:0] wdat;
    logic [31:0] set_v;
    logic       exp_ack;
    int         exp_lat;
    logic [7:0] exp_rd;
    logic [3:0] exp_stb;
    int         exp_stall;
    int         chk_idx;
    logic [7:0] exp_reg;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_ack(input int d);
    return ack[d];
  endfunction

  function automatic logic get_stall(input int d);
    return stall[d];
  endfunction

  function automatic logic [7:0] get_rd(input int d);
    case (d)
      0: return rd0;
      1: return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic [3:0] get_wstb(input int d);
    case (d)
      0: return wstb0;
      1: return wstb1;
      default: return {1'b0, wstb2};
    endcase
  endfunction

  function automatic logic [31:0] get_regs(input int d);
    case (d)
      0: return regs0;
      1: return regs1;
      default: return {8'h00, regs2};
    endcase
  endfunction

  // One request; returns ack seen, latency in cycles, stalled cycles, read data, strobes.
  task automatic xfer(input int d, input logic w, input logic [3:0] pfx, input logic [1:0] idx,
                      input logic [7:0] data, input logic [31:0] set_v, input int budget,
                      output logic got, output int lat, output int stl,
                      output logic [7:0] rdv, output logic [3:0] stbv);
    @(negedge clk);
    addr = {pfx, 14'($urandom), idx};
    wd = data; we = w; stb = 1'b1; cyc[d] = 1'b1; sset = set_v;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0; sset = '0;
    got = 1'b0; lat = 0; stl = 0; rdv = '0; stbv = '0;
    for (int i = 1; i <= budget; i++) begin
      if (get_stall(d)) stl++;
      if (get_ack(d)) begin
        got = 1'b1; lat = i; rdv = get_rd(d); stbv = get_wstb(d);
        break;
      end
      @(negedge clk);
    end
    cyc[d] = 1'b0;
  endtask

  initial begin
    logic        got;
    int          lat, stl;
    logic [7:0]  rdv;
    logic [3:0]  stbv;
    logic [31:0] r;
    vec_t        v;

    //         d  w  pfx   idx  wdat   set_v         ack lat rd     stb      stl chk reg
    vecs[0]  = '{0, 1, 4'h4, 2'd1, 8'h5A, 32'h0,        1,  1, 8'h00, 4'b0010, 1,  1, 8'h5A};
    vecs[1]  = '{0, 0, 4'h4, 2'd1, 8'h00, 32'h0,        1,  1, 8'h5A, 4'b0000, 1, -1, 8'h00};
    vecs[2]  = '{0, 0, 4'h4, 2'd0, 8'h00, 32'h0,        1,  1, 8'h03, 4'b0000, 1, -1, 8'h00};
    vecs[3]  = '{0, 0, 4'h4, 2'd3, 8'h00, 32'h0,        1,  1, 8'hC3, 4'b0000, 1, -1, 8'h00};
    vecs[4]  = '{0, 1, 4'h4, 2'd3, 8'hFF, 32'h0,        1,  1, 8'h00, 4'b1000, 1,  3, 8'h00};
    vecs[5]  = '{0, 0, 4'h4, 2'd2, 8'h00, 32'h0,        1,  1, 8'h09, 4'b0000, 1, -1, 8'h00};
    vecs[6]  = '{0, 1, 4'h4, 2'd2, 8'h01, 32'h0,        1,  1, 8'h00, 4'b0100, 1,  2, 8'h08};
    vecs[7]  = '{0, 0, 4'h4, 2'd2, 8'h00, 32'h0,        1,  1, 8'h08, 4'b0000, 1, -1, 8'h00};
    vecs[8]  = '{0, 1, 4'h4, 2'd2, 8'h08, 32'h0008_0000, 1, 1, 8'h00, 4'b0100, 1,  2, 8'h08};
    vecs[9]  = '{0, 1, 4'h4, 2'd2, 8'h08, 32'h0,        1,  1, 8'h00, 4'b0100, 1,  2, 8'h00};
    vecs[10] = '{0, 1, 4'h5, 2'd1, 8'h00, 32'h0,        0,  0, 8'h00, 4'b0000, 0,  1, 8'h5A};
    vecs[11] = '{1, 0, 4'h4, 2'd3, 8'h00, 32'h0,        1,  4, 8'hC3, 4'b0000, 4, -1, 8'h00};
    vecs[12] = '{1, 1, 4'h4, 2'd1, 8'h77, 32'h0,        1,  4, 8'h00, 4'b0010, 4,  1, 8'h77};
    vecs[13] = '{2, 1, 4'h4, 2'd3, 8'hFF, 32'h0,        1,  2, 8'h00, 4'b0000, 2, -1, 8'h00};
    vecs[14] = '{2, 0, 4'h4, 2'd3, 8'h00, 32'h0,        1,  2, 8'h00, 4'b0000, 2, -1, 8'h00};
    vecs[15] = '{2, 0, 4'h4, 2'd1, 8'h00, 32'h0,        1,  2, 8'hA5, 4'b0000, 2, -1, 8'h00};
    vecs[16] = '{2, 0, 4'h5, 2'd1, 8'h00, 32'h0,        0,  0, 8'h00, 4'b0000, 0, -1, 8'h00};

    // Asynchronous reset takes effect before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst regs0", regs0, 32'h0000_A503);
    chk("rst regs2", {8'h00, regs2}, 32'h0000_A503);
    chk("rst ack", {29'h0, ack}, 32'h0);
    chk("rst stall", {29'h0, stall}, 32'h0);
    chk("rst data", {24'h0, rd0}, 32'h0);
    chk("rst wstb", {28'h0, wstb0}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Hardware sets W1C bits 0 and 3 of reg2 with no bus activity
    @(negedge clk);
    sset = 32'h0009_0000;
    @(negedge clk);
    sset = '0;
    chk("status set", {24'h0, regs0[23:16]}, 32'h09);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      xfer(v.d, v.w, v.pfx, v.idx, v.wdat, v.set_v, 8, got, lat, stl, rdv, stbv);
      chk($sformatf("v%0d ack", i), {31'h0, got}, {31'h0, v.exp_ack});
      chk($sformatf("v%0d stall", i), 32'(stl), 32'(v.exp_stall));
      if (v.exp_ack) begin
        chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d wstb", i), {28'h0, stbv}, {28'h0, v.exp_stb});
        if (!v.w) chk($sformatf("v%0d rdata", i), {24'h0, rdv}, {24'h0, v.exp_rd});
        @(negedge clk);
        chk($sformatf("v%0d post-ack", i), {19'h0, get_ack(v.d), get_wstb(v.d), get_rd(v.d)}, 32'h0);
      end
      if (v.chk_idx >= 0) begin
        r = get_regs(v.d);
        chk($sformatf("v%0d reg", i), {24'h0, r[v.chk_idx*8 +: 8]}, {24'h0, v.exp_reg});
      end
    end

    // Out-of-range write and non-W1C status sets leave u2 untouched
    chk("u2 regs", {8'h00, regs2}, 32'h0000_A503);

    // Drop the cycle during WAIT of a write to reg0: no ack, no write
    @(negedge clk);
    addr = {4'h4, 14'($urandom), 2'd0}; wd = 8'hFF; we = 1'b1; stb = 1'b1; cyc[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    chk("abort stall in wait", {31'h0, stall[1]}, 32'h1);
    cyc[1] = 1'b0;
    got = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1]) got = 1'b1;
    end
    chk("abort no ack", {31'h0, got}, 32'h0);
    chk("abort stall released", {31'h0, stall[1]}, 32'h0);
    chk("abort reg0", {24'h0, regs1[7:0]}, 32'h03);

    // Reset asserted during the ack cycle clears everything immediately
    @(negedge clk);
    addr = {4'h4, 14'($urandom), 2'd3}; we = 1'b0; stb = 1'b1; cyc[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ack[1]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid-ack reached", {31'h0, got}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid-ack rst ack", {31'h0, ack[1]}, 32'h0);
    chk("mid-ack rst stall", {31'h0, stall[1]}, 32'h0);
    chk("mid-ack rst data", {24'h0, rd1}, 32'h0);
    chk("mid-ack rst regs1", regs1, 32'h0000_A503);
    chk("mid-ack rst regs0", regs0, 32'h0000_A503);
    cyc[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_bank.md
Name: wb_reg_bank

Overview:
- Parametrised Wishbone (pipelined) register bank that replaces the single fixed CPU control register with N registers of configurable width.
- Each bit has a configured type: read/write, read-only (live hardware input), or write-1-to-clear sticky status set by hardware.
- Decodes its own base prefix on the 20-bit system bus and supports configurable wait states.
- Instanced at the register base; later instances serve other control/status groups.

Parameters:
- REG_COUNT, 4: number of registers (>=1).
- DATA_WIDTH, 8: bits per register.
- WB_ADDR_WIDTH, 20: bus address width.
- BASE_WIDTH, 4: width of the decoded base prefix.
- BASE, 4'b0100: prefix matched against wb_addr_i[WB_ADDR_WIDTH-1 -: BASE_WIDTH].
- REG_ADDR_WIDTH, max(1, $clog2(REG_COUNT)): index bits, taken from wb_addr_i[REG_ADDR_WIDTH-1:0].
- RESET_VALUES, '0: packed REG_COUNT*DATA_WIDTH reset image; register r occupies [r*DATA_WIDTH +: DATA_WIDTH].
- WRITE_MASK, '1: packed per-bit mask; 1 = RW.
- W1C_MASK, '0: packed per-bit mask; 1 = W1C sticky. Takes precedence over WRITE_MASK.
- WAIT_STATES, 0: extra cycles inserted before ack (0..15).

Ports:
- wb_clock_i, in, 1: system clock.
- wb_reset_n_i, in, 1: asynchronous active-low reset.
- wb_addr_i, in, WB_ADDR_WIDTH: bus address.
- wb_data_i, in, DATA_WIDTH: write data.
- wb_data_o, out, DATA_WIDTH: read data; valid only while wb_ack_o=1.
- wb_we_i, in, 1: 1 = write.
- wb_cycle_i, in, 1: bus cycle active.
- wb_strobe_i, in, 1: transfer request.
- wb_stall_o, out, 1: request not accepted this cycle.
- wb_ack_o, out, 1: transfer complete.
- ro_i, in, REG_COUNT*DATA_WIDTH: live values for read-only bits.
- status_set_i, in, REG_COUNT*DATA_WIDTH: per-bit set pulses for W1C bits.
- regs_o, out, REG_COUNT*DATA_WIDTH: current register image. RO bits are output as 0.
- write_strobe_o, out, REG_COUNT: one-cycle pulse per register written.

Behaviour:
- Reset (asynchronous, wb_reset_n_i=0): all outputs and state are forced immediately.
  - regs_o RW/W1C bits = RESET_VALUES.
  - wb_ack_o=0, wb_stall_o=0, wb_data_o=0, write_strobe_o=0.
  - FSM = IDLE.
  - A reset asserted mid-transfer drops that transfer: no ack and no write.
- Select condition: wb_cycle_i & wb_strobe_i & prefix==BASE & FSM==IDLE.
  - Address bits between the prefix and the index are don't-care.
- FSM has three states.
  - IDLE:
    - On select, latch index, data and we.
    - Go to WAIT if WAIT_STATES>0, else to ACK.
    - wb_stall_o=0.
  - WAIT:
    - Counts WAIT_STATES cycles, then goes to ACK.
    - wb_stall_o=1.
    - If wb_cycle_i falls during WAIT, abort to IDLE with no ack and no write.
  - ACK:
    - wb_ack_o=1 for exactly one cycle, then back to IDLE.
    - wb_stall_o=1.
- Latency: ack is asserted 1+WAIT_STATES cycles after the accepting edge.
  - Back-to-back throughput is one transfer per 2+WAIT_STATES cycles.
- Write: committed on the edge that enters ACK.
  - regs_o shows the new value during the ack cycle.
  - write_strobe_o[index] pulses in the ack cycle.
  - Per bit: RW bit <= data. W1C bit is cleared where data=1 and held where data=0. RO bits are unaffected.
- Read: wb_data_o captured on the edge that enters ACK.
  - Value = RW/W1C register bits merged with ro_i for RO bits.
  - wb_data_o returns to 0 after the ack cycle.
- Out-of-range index (>=REG_COUNT): acked normally, read returns 0, write ignored, no write_strobe_o.
- status_set_i: sets W1C bits every cycle, independent of bus activity. It is ignored on non-W1C bits.
- Same-edge set and W1C clear of the same bit: set wins, so the bit stays 1.
- ro_i is sampled without synchronisation; the caller synchronises it.

Test Plan:
- Reset with RESET_VALUES=32'h00_00_A5_03 -> regs_o=32'h0000A503, ack=0, stall=0.
- Write 8'h5A to reg 1 (BASE prefix, middle bits random) with WAIT_STATES=0 -> ack on the next cycle, regs_o[15:8]=8'h5A, write_strobe_o=4'b0010 for one cycle.
- Reg 2 with W1C_MASK byte 8'hFF:
  - pulse status_set_i bits 0 and 3 -> read returns 8'h09.
  - write 8'h01 -> reads 8'h08.
  - write 8'h08 on the same edge as status_set bit 3 -> bit 3 stays 1.
- WAIT_STATES=3 read of reg 3 (RO, ro_i=8'hC3) -> stall=1 for 4 cycles, ack exactly 4 cycles after acceptance, data 8'hC3.
- Drop wb_cycle_i during WAIT of a write 8'hFF to reg 0 -> no ack, reg 0 unchanged. Assert reset mid-ACK -> outputs return to reset values at once.
- Access index 3 with REG_COUNT=3, and access with a wrong prefix 4'b0101 -> out-of-range is acked with data 0 and no write; wrong prefix gives no ack and no stall.
